multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 The block SHALL have one clock and one reset: clk input 1, rising-edge clock; rst input 1, synchronous, active-high reset.
REQ-002 The block SHALL provide these inputs: en input 1 (allow new fetch); opcode input 7 (instruction register bits [6:0]); zero input 1 (ALU zero flag); mem_ready input 1 (memory completes the current access this cycle).
REQ-003 The block SHALL provide these memory outputs: mem_req output 1 (memory access requested); MemRead output 1; MemWrite output 1; IorD output 1 (0 = PC address, 1 = ALUOut address).
REQ-004 The block SHALL provide these register-enable outputs: IRWrite output 1 (load IR and old-PC); PCWrite output 1; RegWrite output 1.
REQ-005 The block SHALL provide these mux and ALU outputs: ALUSrcA output 1 (0 = old-PC, 1 = reg A); ALUSrcB output 2 (00 = reg B, 01 = const 4, 10 = imm, 11 = imm<<1); ALUOp output 2 (00 = add, 01 = sub, 10 = funct-decoded); MemtoReg output 1; PCSource output 1 (0 = ALU result, 1 = ALUOut).
REQ-006 The block SHALL provide these status outputs: state output 4 (current state code); illegal output 1 (sticky illegal-opcode flag); retired output 32 (retired-instruction count); retire output 1 (one-cycle pulse per retired instruction).

Function
REQ-007 State codes SHALL be: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, TRAP=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-008 All outputs not listed for a state SHALL be 0 in that state.
REQ-009 FETCH behaviour: if en=0, hold in FETCH with mem_req=0. If en=1: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00. IRWrite, PCWrite and PCSource=0 SHALL assert only in the same cycle as mem_ready=1, then go to DECODE. mem_ready=0 keeps the block in FETCH.
REQ-010 DECODE behaviour: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode: 0110011 -> EXEC_R; 0010011 -> EXEC_I; 0000011 or 0100011 -> MEM_ADDR; 1100011 -> BRANCH; any other value -> TRAP.
REQ-011 EXEC_R SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to WB_ALU. EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=10, then go to WB_ALU.
REQ-012 MEM_ADDR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEM_RD if the opcode is a load, MEM_WR if it is a store.
REQ-013 MEM_RD SHALL drive mem_req=1, MemRead=1, IorD=1. It waits while mem_ready=0 and goes to WB_MEM when mem_ready=1.
REQ-014 MEM_WR SHALL drive mem_req=1, MemWrite=1, IorD=1. It waits while mem_ready=0; when mem_ready=1 it retires and goes to FETCH.
REQ-015 WB_ALU SHALL drive RegWrite=1, MemtoReg=0. WB_MEM SHALL drive RegWrite=1, MemtoReg=1. Both SHALL retire and go to FETCH.
REQ-016 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=1, PCWrite=zero (combinational), then retire and go to FETCH.
REQ-017 TRAP SHALL hold illegal=1 with all control outputs 0, and SHALL leave TRAP only on rst.
REQ-018 On each retire, retire SHALL be 1 for exactly that cycle and retired SHALL increment by 1 on that clock edge, wrapping from 0xFFFFFFFF to 0.
REQ-019 mem_ready SHALL be ignored in every state where mem_req=0.
REQ-020 en SHALL be sampled only in FETCH; an instruction in progress SHALL complete regardless of en.
REQ-021 Every output except IRWrite, PCWrite, retire and the FETCH/BRANCH PCWrite qualifier SHALL be a function of state only (Moore).

Reset
REQ-022 On the first rising clk edge with rst=1, the block SHALL load state=FETCH, illegal=0 and retired=0, from any state including mid-access.
REQ-023 While rst=1, mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite and retire SHALL all be 0.
REQ-024 rst SHALL take priority over mem_ready and en in the same cycle.

Verification
REQ-025 Reset release, en=1, opcode=0110011, mem_ready=1 every cycle -> states 0,1,2,7,0; retire pulses once; retired=1 after 4 cycles.
REQ-026 Load opcode 0000011, mem_ready low for 3 cycles in MEM_RD -> MEM_RD held 4 cycles with mem_req=1, IorD=1; then WB_MEM with RegWrite=1 and MemtoReg=1.
REQ-027 Branch opcode 1100011: zero=1 -> PCWrite=1 and PCSource=1 in BRANCH; zero=0 -> PCWrite=0; retire=1 in both cases.
REQ-028 opcode=1111111 in DECODE -> TRAP (state=10), illegal=1 held for 20 cycles with all enables 0; rst -> state=0 and illegal=0.
REQ-029 rst asserted in MEM_WR with mem_ready=1 in the same cycle -> no retire; next state=FETCH; retired unchanged from reset value 0.
REQ-030 retired preset to 0xFFFFFFFF by running that many retires (or by a forced state), then one more retire -> retired=0x00000000; en=0 in FETCH -> mem_req stays 0 and state stays 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath mux/enable controls and keeps a retired-instruction count.
module multicycle_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic        MemtoReg,
  output logic        PCSource,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired,
  output logic        retire
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t      state_q, state_d;
  logic        illegal_q;
  logic [31:0] retired_q;

  // Raw strobes before reset gating; reset must silence them combinationally.
  logic mem_req_c, mem_rd_c, mem_wr_c, ir_wr_c, pc_wr_c, reg_wr_c, retire_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_TRAP) illegal_q <= 1'b1;
      if (retire_c)          retired_q <= retired_q + 32'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    ir_wr_c   = 1'b0;
    pc_wr_c   = 1'b0;
    reg_wr_c  = 1'b0;
    retire_c  = 1'b0;
    IorD      = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ALUOp     = 2'b00;
    MemtoReg  = 1'b0;
    PCSource  = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB = 2'b01;
        if (en) begin
          mem_req_c = 1'b1;
          mem_rd_c  = 1'b1;
          if (mem_ready) begin
            ir_wr_c = 1'b1;
            pc_wr_c = 1'b1;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_WB_ALU;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        state_d = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        // IR is stable here, so anything but load/store means a corrupted decode.
        if (opcode == OP_LOAD)       state_d = S_MEM_RD;
        else if (opcode == OP_STORE) state_d = S_MEM_WR;
        else                         state_d = S_TRAP;
      end
      S_MEM_RD: begin
        mem_req_c = 1'b1;
        mem_rd_c  = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req_c = 1'b1;
        mem_wr_c  = 1'b1;
        IorD      = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_WB_ALU: begin
        reg_wr_c = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_WB_MEM: begin
        reg_wr_c = 1'b1;
        MemtoReg = 1'b1;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b01;
        PCSource = 1'b1;
        pc_wr_c  = zero;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  assign mem_req  = mem_req_c & ~rst;
  assign MemRead  = mem_rd_c  & ~rst;
  assign MemWrite = mem_wr_c  & ~rst;
  assign IRWrite  = ir_wr_c   & ~rst;
  assign PCWrite  = pc_wr_c   & ~rst;
  assign RegWrite = reg_wr_c  & ~rst;
  assign retire   = retire_c  & ~rst;
  assign state    = state_q;
  assign illegal  = illegal_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: each issued instruction pushes its expected state walk;
// a negedge monitor checks per-cycle controls and pops on every retire.
module tb_multicycle_control_unit;
  logic        clk = 1'b0;
  logic        rst, en, zero, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite;
  logic        ALUSrcA, MemtoReg, PCSource, illegal, retire;
  logic [1:0]  ALUSrcB, ALUOp;
  logic [3:0]  state;
  logic [31:0] retired;

  multicycle_control_unit dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .MemtoReg(MemtoReg), .PCSource(PCSource),
    .state(state), .illegal(illegal), .retired(retired), .retire(retire)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011;
  localparam logic [6:0] OP_S = 7'b0100011, OP_B = 7'b1100011;

  typedef struct { logic [31:0] path; int len; } exp_t;
  exp_t        sbq[$];
  logic [31:0] exp_retired;
  int          checks = 0, errors = 0;
  bit          mr_rand = 0, zr_rand = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Instruction class -> sequence of distinct states it walks through.
  function automatic exp_t walk(logic [6:0] op);
    exp_t e;
    case (op)
      OP_R:    begin e.path = 32'h0127;  e.len = 4; end
      OP_I:    begin e.path = 32'h0137;  e.len = 4; end
      OP_L:    begin e.path = 32'h01458; e.len = 5; end
      OP_S:    begin e.path = 32'h0146;  e.len = 4; end
      default: begin e.path = 32'h019;   e.len = 3; end
    endcase
    return e;
  endfunction

  // Control table per state: {mem_req,MemRead,MemWrite,IorD,IRWrite,PCWrite,
  // RegWrite,ALUSrcA,ALUSrcB,ALUOp,MemtoReg,PCSource,retire}.
  function automatic logic [14:0] exp_ctl(logic [3:0] s, logic e, logic mr, logic z);
    logic mq, rd, wr, ad, ir, pw, rw, sa, mt, ps, rt;
    logic [1:0] sb, op;
    {mq, rd, wr, ad, ir, pw, rw, sa, mt, ps, rt} = '0;
    sb = 2'b00; op = 2'b00;
    case (s)
      4'd0: begin sb = 2'b01; if (e) begin mq = 1; rd = 1; ir = mr; pw = mr; end end
      4'd1: sb = 2'b11;
      4'd2: begin sa = 1; op = 2'b10; end
      4'd3: begin sa = 1; sb = 2'b10; op = 2'b10; end
      4'd4: begin sa = 1; sb = 2'b10; end
      4'd5: begin mq = 1; rd = 1; ad = 1; end
      4'd6: begin mq = 1; wr = 1; ad = 1; rt = mr; end
      4'd7: begin rw = 1; rt = 1; end
      4'd8: begin rw = 1; mt = 1; rt = 1; end
      4'd9: begin sa = 1; op = 2'b01; ps = 1; pw = z; rt = 1; end
      default: ;
    endcase
    return {mq, rd, wr, ad, ir, pw, rw, sa, sb, op, mt, ps, rt};
  endfunction

  always @(posedge clk) begin
    #1;
    if (mr_rand) mem_ready = 1'($urandom_range(0, 1));
    if (zr_rand) zero      = 1'($urandom_range(0, 1));
  end

  // Monitor / scoreboard.
  logic [31:0] obs = 0;
  int          olen = 0;
  logic [3:0]  prev = 4'hf;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rst_strobes", {mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, retire}, 0);
      obs = 0; olen = 0; prev = 4'hf;
    end else begin
      chk("ctl", {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, MemtoReg, PCSource, retire},
          exp_ctl(state, en, mem_ready, zero));
      chk("illegal", illegal, 32'(state == 4'd10));
      if (state != prev) begin obs = (obs << 4) | 32'(state); olen++; prev = state; end
      if (retire) begin
        if (sbq.size() == 0) chk("retire_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("path", obs, e.path);
          chk("path_len", olen, e.len);
        end
        chk("retired_count", retired, exp_retired);
        exp_retired = exp_retired + 1;
        obs = 0; olen = 0;
      end
    end
  end

  task automatic do_reset();
    rst = 1; en = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    sbq.delete();
    exp_retired = 0;
    @(negedge clk);
    chk("post_rst_state", state, 0);
    chk("post_rst_illegal", illegal, 0);
    chk("post_rst_retired", retired, 0);
    @(posedge clk); #1;
  endtask

  task automatic wait_state(logic [3:0] s);
    int k = 0;
    do begin @(negedge clk); k++; end while (state != s && k < 100);
    chk("wait_state", state, 32'(s));
  endtask

  // Called at posedge+1; returns at posedge+1 with en dropped, idle in FETCH.
  task automatic issue(logic [6:0] op);
    int k = 0;
    opcode = op; en = 1;
    sbq.push_back(walk(op));
    do begin @(negedge clk); k++; end while (!retire && k < 200);
    chk("retire_seen", retire, 1);
    if (op == OP_B) begin
      chk("br_pcwrite", PCWrite, 32'(zero));
      chk("br_pcsource", PCSource, 1);
    end
    @(posedge clk); #1 en = 0;
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk);
      chk("idle_state", state, 0);
      chk("idle_mem_req", mem_req, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [3:0] seq [5] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd0};
    logic [6:0] ops [5] = '{OP_R, OP_I, OP_L, OP_S, OP_B};
    logic [6:0] bad;
    rst = 1; en = 0; zero = 0; mem_ready = 0; opcode = OP_R; exp_retired = 0;
    do_reset();

    // Back-to-back R-type with memory always ready.
    mem_ready = 1; opcode = OP_R; en = 1;
    sbq.push_back(walk(OP_R));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("r_seq_state", state, 32'(seq[i]));
      if (i == 3) begin chk("r_seq_retire", retire, 1); @(posedge clk); #1 en = 0; end
      if (i == 4) chk("r_seq_retired", retired, 1);
    end
    @(posedge clk); #1;

    // Load with three not-ready cycles in MEM_RD.
    opcode = OP_L; en = 1; sbq.push_back(walk(OP_L));
    wait_state(4'd4);
    @(posedge clk); #1 mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      @(negedge clk);
      chk("ld_wait_state", state, 5);
      chk("ld_wait_req_iord", {mem_req, IorD}, 2'b11);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ld_wb_state", state, 8);
    chk("ld_wb_ctl", {RegWrite, MemtoReg, retire}, 3'b111);
    @(posedge clk); #1 en = 0;

    // Branch taken and not taken.
    zero = 1; issue(OP_B);
    zero = 0; issue(OP_B);

    // Illegal opcode traps until reset.
    opcode = 7'b1111111; en = 1;
    wait_state(4'd10);
    en = 0;
    repeat (20) begin
      @(negedge clk);
      chk("trap_state", state, 10);
      chk("trap_illegal", illegal, 1);
      chk("trap_enables", {mem_req, MemRead, MemWrite, IRWrite, PCWrite, RegWrite, retire}, 0);
    end
    @(posedge clk); #1;
    do_reset();

    // Reset wins over a completing store.
    mem_ready = 1; opcode = OP_S; en = 1;
    wait_state(4'd4);
    @(posedge clk); #1 mem_ready = 0; en = 0;
    @(negedge clk);
    chk("st_hold_state", state, 6);
    @(posedge clk); #1 rst = 1; mem_ready = 1;
    @(negedge clk);
    chk("st_rst_retire", retire, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("st_rst_state", state, 0);
    chk("st_rst_retired", retired, 0);
    @(posedge clk); #1;

    // Idle with memory ready: en=0 must not start a fetch.
    idle(5);

    // Counter wrap.
    force dut.retired_q = 32'hFFFF_FFFF;
    @(posedge clk); #1 release dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("preset_retired", retired, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    issue(OP_I);
    @(negedge clk);
    chk("wrap_retired", retired, 0);
    @(posedge clk); #1;
    do_reset();

    // Randomized mix with random memory latency and zero flag.
    mr_rand = 1; zr_rand = 1;
    for (int n = 0; n < 60; n++) begin
      issue(ops[$urandom_range(0, 4)]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Random illegal opcode.
    do bad = 7'($urandom); while (bad == OP_R || bad == OP_I || bad == OP_L ||
                                  bad == OP_S || bad == OP_B);
    opcode = bad; en = 1;
    wait_state(4'd10);
    en = 0;
    @(posedge clk); #1;
    do_reset();

    chk("queue_drained", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end
endmodule
